// File: rtl/posit_pack_round_pipe.sv
// Two-stage posit packer: stage 1 assembles the regime/exponent/fraction
// string and truncates it, stage 2 applies round-to-nearest-even, the
// minpos/maxpos guards, the sign and the zero/NaR specials.
module posit_pack_round_pipe #(
  parameter int BITS = 32,
  parameter int ES   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sign,
  input  logic [BITS-1:0]             in_seed,
  input  logic [((ES > 0) ? ES : 1)-1:0] in_exp,
  input  logic [BITS-1:0]             in_frac,
  input  logic                        in_sticky,
  input  logic                        in_zero,
  input  logic                        in_nar,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BITS-1:0]             out_posit,
  output logic                        out_inexact
);

  // Full string: longest regime (BITS-1) followed by exponent and fraction.
  localparam int L  = (BITS - 1) + ES + BITS;
  localparam int TW = ES + BITS;
  localparam int SW = $clog2(L + 1);

  localparam logic signed [BITS-1:0] KMAX = BITS'(BITS - 2);
  localparam logic signed [BITS-1:0] KMIN = -KMAX;

  // Handshake
  logic s2_drains;
  logic s1_moves;

  // Stage 1 combinational build
  logic [TW-1:0]          tail;
  logic [L-1:0]           tail_la;
  logic signed [BITS-1:0] seed;
  logic signed [BITS-1:0] k;
  logic                   sat_pos;
  logic                   sat_neg;
  logic [SW-1:0]          run_len;
  logic [SW-1:0]          rlen;
  logic [L-1:0]           regime;
  logic [L-1:0]           full;
  logic [BITS-2:0]        b_m;
  logic                   b_guard;
  logic                   b_sticky;

  // Stage 1 registers
  logic                   s1_valid_q,  s1_valid_d;
  logic [BITS-2:0]        s1_m_q,      s1_m_d;
  logic                   s1_guard_q,  s1_guard_d;
  logic                   s1_sticky_q, s1_sticky_d;
  logic                   s1_sign_q,   s1_sign_d;
  logic                   s1_zero_q,   s1_zero_d;
  logic                   s1_nar_q,    s1_nar_d;
  logic                   s1_sat_q,    s1_sat_d;

  // Stage 2 combinational round and registers
  logic                   inc;
  logic [BITS-2:0]        m_rnd;
  logic [BITS-1:0]        mag;
  logic [BITS-1:0]        r_posit;
  logic                   r_inexact;
  logic                   s2_valid_q,    s2_valid_d;
  logic [BITS-1:0]        out_posit_q,   out_posit_d;
  logic                   out_inexact_q, out_inexact_d;

  assign s2_drains = !s2_valid_q || out_ready;
  assign s1_moves  = s1_valid_q && s2_drains;
  assign in_ready  = !s1_valid_q || s1_moves;

  // Exponent bits (if any) sit directly in front of the fraction.
  generate
    if (ES > 0) begin : g_exp
      assign tail = {in_exp[ES-1:0], in_frac};
    end else begin : g_noexp
      assign tail = in_frac;
    end
  endgenerate

  assign tail_la = {tail, {(BITS-1){1'b0}}};

  // Clamp k, build the regime string, truncate to BITS-1 bits plus guard/sticky.
  always_comb begin
    // NOTE: every signal gets a value on every path so no latch is inferred.
    seed    = $signed(in_seed);
    sat_pos = seed > KMAX;
    sat_neg = seed < KMIN;
    k       = sat_pos ? KMAX : (sat_neg ? KMIN : seed);
    run_len = '0;
    rlen    = '0;
    regime  = '0;
    if (!k[BITS-1]) begin
      // k+1 ones, then a terminating zero unless the field is already full.
      run_len = SW'(k) + SW'(1);
      regime  = ~({L{1'b1}} >> run_len);
      rlen    = (k == KMAX) ? run_len : run_len + SW'(1);
    end else begin
      // -k zeros, then a terminating one.
      run_len = SW'(-k);
      regime  = {1'b1, {(L-1){1'b0}}} >> run_len;
      rlen    = run_len + SW'(1);
    end
    full     = regime | (tail_la >> rlen);
    b_m      = full[L-1 -: BITS-1];
    b_guard  = full[L-BITS];
    b_sticky = (|full[L-BITS-1:0]) | in_sticky;
    // A clamped k means the true value lies beyond the boundary posit.
    if (sat_pos || sat_neg) begin
      b_guard  = 1'b1;
      b_sticky = 1'b1;
    end
  end

  // Stage 1 next state: load on acceptance, otherwise hold or empty.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_m_d      = s1_m_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_sign_d   = s1_sign_q;
    s1_zero_d   = s1_zero_q;
    s1_nar_d    = s1_nar_q;
    s1_sat_d    = s1_sat_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_m_d      = b_m;
        s1_guard_d  = b_guard;
        s1_sticky_d = b_sticky;
        s1_sign_d   = in_sign;
        s1_zero_d   = in_zero;
        s1_nar_d    = in_nar;
        s1_sat_d    = sat_pos || sat_neg;
      end
    end
  end

  // Round to nearest even, keep within [minpos, maxpos], apply sign and specials.
  always_comb begin
    // The clamp already picked the boundary value, so saturated beats never move.
    inc   = s1_guard_q && (s1_m_q[0] || s1_sticky_q) && !s1_sat_q && !(&s1_m_q);
    m_rnd = s1_m_q + {{(BITS-2){1'b0}}, inc};
    if (m_rnd == '0) begin
      m_rnd = {{(BITS-2){1'b0}}, 1'b1};
    end
    mag       = {1'b0, m_rnd};
    r_posit   = s1_sign_q ? -mag : mag;
    r_inexact = s1_guard_q || s1_sticky_q;
    if (s1_nar_q) begin
      r_posit   = {1'b1, {(BITS-1){1'b0}}};
      r_inexact = 1'b0;
    end else if (s1_zero_q) begin
      r_posit   = '0;
      r_inexact = 1'b0;
    end
  end

  // Stage 2 next state: refill whenever the output slot drains.
  always_comb begin
    s2_valid_d    = s2_valid_q;
    out_posit_d   = out_posit_q;
    out_inexact_d = out_inexact_q;
    if (s2_drains) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_posit_d   = r_posit;
        out_inexact_d = r_inexact;
      end
    end
  end

  // Control and output state with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_posit_q   <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s2_valid_q    <= s2_valid_d;
      out_posit_q   <= out_posit_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  // Stage 1 payload.
  always_ff @(posedge clk) begin
    // NOTE: payload is qualified by s1_valid_q, so it needs no reset.
    s1_m_q      <= s1_m_d;
    s1_guard_q  <= s1_guard_d;
    s1_sticky_q <= s1_sticky_d;
    s1_sign_q   <= s1_sign_d;
    s1_zero_q   <= s1_zero_d;
    s1_nar_q    <= s1_nar_d;
    s1_sat_q    <= s1_sat_d;
  end

  assign out_valid   = s2_valid_q;
  assign out_posit   = out_posit_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_posit_pack_round_pipe.sv
// Bench for posit_pack_round_pipe at BITS=8, ES=1: a bit-string reference
// model with a scoreboard, directed vectors, backpressure and reset flush.
module tb_posit_pack_round_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [7:0] in_seed;
  logic [0:0] in_exp;
  logic [7:0] in_frac;
  logic       in_sticky;
  logic       in_zero;
  logic       in_nar;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_posit;
  logic       out_inexact;

  typedef struct {
    logic       sign;
    logic [7:0] seed;
    logic       ex;
    logic [7:0] frac;
    logic       sticky;
    logic       zero;
    logic       nar;
    logic [8:0] res;   // {inexact, posit}, hand-computed
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] sb[$];
  vec_t       tbl[$];
  logic       stall_prev = 1'b0;
  logic [8:0] stall_val;

  posit_pack_round_pipe #(.BITS(8), .ES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_seed    (in_seed),
    .in_exp     (in_exp),
    .in_frac    (in_frac),
    .in_sticky  (in_sticky),
    .in_zero    (in_zero),
    .in_nar     (in_nar),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_posit  (out_posit),
    .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: expected event did not happen", name);
  endtask

  // Reference: write out the posit bit string, cut it, round it as an integer.
  function automatic logic [8:0] model(input logic sign, input logic [7:0] seed,
                                       input logic ex, input logic [7:0] frac,
                                       input logic sticky, input logic zero,
                                       input logic nar);
    int   k;
    int   m;
    bit   q[$];
    bit   g;
    bit   s;
    bit   inx;
    logic [7:0] p;
    if (nar)  return {1'b0, 8'h80};
    if (zero) return 9'h000;
    k = int'($signed(seed));
    if (k > 6) begin
      m = 127; inx = 1'b1;
    end else if (k < -6) begin
      m = 1; inx = 1'b1;
    end else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        if (k < 6) q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(ex);
      for (int i = 7; i >= 0; i--) q.push_back(frac[i]);
      m = 0;
      for (int i = 0; i < 7; i++) m = m * 2 + int'(q[i]);
      g = q[7];
      s = sticky;
      for (int i = 8; i < q.size(); i++) s = s | q[i];
      if (g && ((m % 2) == 1 || s) && m != 127) m = m + 1;
      if (m == 0) m = 1;
      inx = g | s;
    end
    p = sign ? 8'(256 - m) : 8'(m);
    return {inx, p};
  endfunction

  // Scoreboard: record accepted beats, compare emitted ones, watch stalls.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid)
        check("stall_hold", {23'd0, out_inexact, out_posit}, {23'd0, stall_val});
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_inexact, out_posit};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail_now("unexpected_output");
        else check("stream", {23'd0, out_inexact, out_posit}, {23'd0, sb.pop_front()});
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_sign, in_seed, in_exp[0], in_frac, in_sticky, in_zero, in_nar));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic sign, input logic [7:0] seed, input logic ex,
                     input logic [7:0] frac, input logic sticky, input logic zero,
                     input logic nar, input logic [8:0] res);
    vec_t v;
    v.sign = sign; v.seed = seed; v.ex = ex; v.frac = frac;
    v.sticky = sticky; v.zero = zero; v.nar = nar; v.res = res;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_sign   = v.sign;
    in_seed   = v.seed;
    in_exp[0] = v.ex;
    in_frac   = v.frac;
    in_sticky = v.sticky;
    in_zero   = v.zero;
    in_nar    = v.nar;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input vec_t v);
    int n;
    drive(v);
    in_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (n == 50) fail_now("send_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    for (n = 0; n < 20; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    vec_t v;
    vec_t bp[4];
    int   acc;
    int   idx;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_seed = '0; in_exp = '0; in_frac = '0;
    in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;

    //        sign seed   ex frac   stk zero nar  {inexact,posit}
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h040);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h0C0);
    add(1'b0, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h17F);
    add(1'b0, 8'hF6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h101);
    add(1'b1, 8'hF6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h1FF);
    add(1'b0, 8'h06, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 9'h17F);
    add(1'b0, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 9'h140);
    add(1'b0, 8'h00, 1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 9'h142);
    add(1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 9'h141);
    add(1'b0, 8'h00, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0, 9'h150);
    add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 9'h080);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 9'h000);
    add(1'b0, 8'h02, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 9'h177);
    add(1'b1, 8'hFE, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 9'h0EC);
    add(1'b0, 8'h05, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 9'h17F);
    add(1'b0, 8'hFA, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 9'h102);
    add(1'b1, 8'h03, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 9'h080);

    // Hand-computed values pin the model itself.
    for (int i = 0; i < tbl.size(); i++)
      check($sformatf("model_%0d", i),
            {23'd0, model(tbl[i].sign, tbl[i].seed, tbl[i].ex, tbl[i].frac,
                          tbl[i].sticky, tbl[i].zero, tbl[i].nar)},
            {23'd0, tbl[i].res});

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_posit", out_posit, 0);
    check("rst_out_inexact", out_inexact, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Latency: accepted now, visible two cycles later.
    drive(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_cycle2_posit", out_posit, 32'h40);
    @(posedge clk); #1;
    wait_drain("lat_drain");

    // Directed vectors back to back.
    foreach (tbl[i]) send(tbl[i]);
    in_valid = 1'b0;
    wait_drain("directed_drain");

    // Backpressure: four beats offered while the output is stalled.
    for (int i = 0; i < 4; i++) begin
      bp[i] = tbl[0];
      bp[i].frac = 8'(i * 16);   // posits 0x40..0x43 reveal ordering
    end
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) drive(bp[idx]);
      in_valid = (idx < 4);
      @(negedge clk);
      if (in_valid && in_ready) begin acc++; idx++; end
      @(posedge clk); #1;
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) drive(bp[idx]);
      @(negedge clk);
      check($sformatf("bp_stream_valid_%0d", c), out_valid, 1);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 4);
    wait_drain("bp_drain");

    // Reset with both stages full: the two beats must vanish.
    out_ready = 1'b0;
    v = tbl[12];
    send(v);
    v = tbl[13];
    send(v);
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_valid", out_valid, 1);
    check("flush_full_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("flush_quiet_%0d", c), out_valid, 0);
    end
    @(posedge clk); #1;

    // Pipeline still works after the flush.
    send(tbl[7]);
    in_valid = 1'b0;
    wait_drain("post_flush_drain");

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
